mcpu_ifetch: RTL and testbench

Instruction prefetch controller for the MCPU dual-read-port instruction ROM.
- Sequences both IROM read ports so up to two consecutive bytes are fetched per cycle into a small circular byte queue.
- Presents the two head bytes and the head PC to the decoder, which consumes 0, 1 or 2 bytes per cycle.
- Handles control-flow redirects by flushing the queue and restarting fetch at the new address.

---
 rtl/mcpu_ifetch_pkg.sv | 21 ++
 rtl/mcpu_defs.vh | 16 +
 rtl/mcpu_ifetch_queue.sv | 67 ++++++
 rtl/mcpu_ifetch.sv | 135 +++++++++++++
 tb/tb_mcpu_ifetch.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mcpu_ifetch_pkg.sv
// ============================================================================
// mcpu_ifetch_pkg
// Types and constants shared by the instruction prefetch controller.
// Revision: 1.0
// ============================================================================
`include "mcpu_defs.vh"
`default_nettype none

package mcpu_ifetch_pkg;

  localparam int unsigned DEF_IROM_ADDR_BITS = `MCPU_IROM_ADDR_BITS;
  localparam int unsigned MAX_POP            = `MCPU_MAX_POP;

  typedef enum logic {
    ST_IDLE = `MCPU_ST_IDLE,
    ST_RUN  = `MCPU_ST_RUN
  } ifetch_state_e;

endpackage

`default_nettype wire

// File: rtl/mcpu_defs.vh
// ============================================================================
// mcpu_defs.vh
// Shared MCPU constants: default IROM width, IFETCH state codes, max pop.
// Revision: 1.0
// ============================================================================
`ifndef MCPU_DEFS_VH
`define MCPU_DEFS_VH
`default_nettype none

`define MCPU_IROM_ADDR_BITS 14
`define MCPU_ST_IDLE        1'b0
`define MCPU_ST_RUN         1'b1
`define MCPU_MAX_POP        2

`default_nettype wire
`endif

// File: rtl/mcpu_ifetch_queue.sv
// ============================================================================
// mcpu_ifetch_queue
// Circular byte queue, 0..2 push and 0..2 pop per cycle, two head bytes.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mcpu_ifetch_queue #(
  parameter int unsigned QDEPTH = 4,
  localparam int unsigned PW    = $clog2(QDEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic [1:0]    push_i,
  input  logic [7:0]    wdata0_i,
  input  logic [7:0]    wdata1_i,
  input  logic [1:0]    pop_i,
  output logic [7:0]    head0_o,
  output logic [7:0]    head1_o,
  output logic [CW-1:0] count_o
);

  logic [7:0]    mem_q [QDEPTH];
  logic [PW-1:0] rptr_q;
  logic [PW-1:0] wptr_q;
  logic [CW-1:0] count_q;
  logic [PW-1:0] rptr_nxt;
  logic [PW-1:0] wptr_nxt;

  assign rptr_nxt = rptr_q + PW'(1);
  assign wptr_nxt = wptr_q + PW'(1);

  // Caller guarantees push fits pre-pop free space and pop <= count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i != 2'd0) begin
        mem_q[wptr_q] <= wdata0_i;
      end
      if (push_i == 2'd2) begin
        mem_q[wptr_nxt] <= wdata1_i;
      end
      wptr_q  <= wptr_q + PW'(push_i);
      rptr_q  <= rptr_q + PW'(pop_i);
      count_q <= count_q - CW'(pop_i) + CW'(push_i);
    end
  end

  assign head0_o = mem_q[rptr_q];
  assign head1_o = mem_q[rptr_nxt];
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/mcpu_ifetch.sv
// ============================================================================
// mcpu_ifetch
// Instruction prefetch controller driving both IROM read ports into a byte
// queue. Optional counters enabled by MCPU_IFETCH_PERF_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mcpu_ifetch
  import mcpu_ifetch_pkg::*;
#(
  parameter int unsigned                IROM_ADDR_BITS = DEF_IROM_ADDR_BITS,
  parameter int unsigned                QDEPTH         = 4,
  parameter logic [IROM_ADDR_BITS-1:0]  RESET_PC       = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      redirect_valid,
  input  logic [IROM_ADDR_BITS-1:0] redirect_addr,
  output logic [IROM_ADDR_BITS-1:0] irom_addr0,
  output logic [IROM_ADDR_BITS-1:0] irom_addr1,
  input  logic [7:0]                irom_out0,
  input  logic [7:0]                irom_out1,
  input  logic [1:0]                pop,
  output logic [7:0]                q_byte0,
  output logic [7:0]                q_byte1,
  output logic [$clog2(QDEPTH):0]   q_count,
  output logic [IROM_ADDR_BITS-1:0] q_pc
`ifdef MCPU_IFETCH_PERF_EN
  ,
  output logic [15:0]               perf_flushes,
  output logic [15:0]               perf_starve
`endif
);

  localparam int unsigned AW = IROM_ADDR_BITS;
  localparam int unsigned CW = $clog2(QDEPTH) + 1;

  ifetch_state_e state_q;
  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] q_pc_q, q_pc_d;
  logic [CW-1:0] count;
  logic [CW-1:0] space;
  logic [1:0]    pop_cap;
  logic [1:0]    eff_pop;
  logic [1:0]    push_cnt;
  logic [1:0]    q_push;
  logic [1:0]    q_pop;

  always_comb begin
    pop_cap  = (pop > 2'(MAX_POP)) ? 2'(MAX_POP) : pop;
    eff_pop  = (CW'(pop_cap) > count) ? count[1:0] : pop_cap;
    // Free space is taken before this cycle's pop retires.
    space    = CW'(QDEPTH) - count;
    push_cnt = 2'd0;
    if (state_q == ST_RUN) begin
      push_cnt = (space >= CW'(MAX_POP)) ? 2'(MAX_POP) : space[1:0];
    end
    q_push     = redirect_valid ? 2'd0 : push_cnt;
    q_pop      = redirect_valid ? 2'd0 : eff_pop;
    fetch_pc_d = redirect_valid ? redirect_addr : fetch_pc_q + AW'(push_cnt);
    q_pc_d     = redirect_valid ? redirect_addr : q_pc_q + AW'(eff_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (en)  state_q <= ST_RUN;
        ST_RUN:  if (!en) state_q <= ST_IDLE;
        default:          state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      q_pc_q     <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      q_pc_q     <= q_pc_d;
    end
  end

  mcpu_ifetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush_i  (redirect_valid),
    .push_i   (q_push),
    .wdata0_i (irom_out0),
    .wdata1_i (irom_out1),
    .pop_i    (q_pop),
    .head0_o  (q_byte0),
    .head1_o  (q_byte1),
    .count_o  (count)
  );

  assign irom_addr0 = fetch_pc_q;
  assign irom_addr1 = fetch_pc_q + AW'(1);
  assign q_count    = count;
  assign q_pc       = q_pc_q;

`ifdef MCPU_IFETCH_PERF_EN
  logic [15:0] perf_flushes_q;
  logic [15:0] perf_starve_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_flushes_q <= 16'h0000;
      perf_starve_q  <= 16'h0000;
    end else begin
      if (redirect_valid && perf_flushes_q != 16'hFFFF) begin
        perf_flushes_q <= perf_flushes_q + 16'd1;
      end
      if (!redirect_valid && state_q == ST_RUN && count == '0 &&
          perf_starve_q != 16'hFFFF) begin
        perf_starve_q <= perf_starve_q + 16'd1;
      end
    end
  end

  assign perf_flushes = perf_flushes_q;
  assign perf_starve  = perf_starve_q;
`else
  // Counter build disabled: no performance state exists.
`endif

endmodule

`default_nettype wire

// File: tb/tb_mcpu_ifetch.sv
// ============================================================================
// tb_mcpu_ifetch
// Self-checking bench for mcpu_ifetch: directed table plus randomized traffic.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mcpu_ifetch;

  localparam int AW   = 14;
  localparam int QD   = 4;
  localparam int MASK = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          redirect_valid;
  logic [AW-1:0] redirect_addr;
  logic [AW-1:0] irom_addr0;
  logic [AW-1:0] irom_addr1;
  logic [7:0]    irom_out0;
  logic [7:0]    irom_out1;
  logic [1:0]    pop;
  logic [7:0]    q_byte0;
  logic [7:0]    q_byte1;
  logic [2:0]    q_count;
  logic [AW-1:0] q_pc;
`ifdef MCPU_IFETCH_PERF_EN
  logic [15:0]   perf_flushes;
  logic [15:0]   perf_starve;
`endif

  logic [7:0] irom [0:(1<<AW)-1];

  assign irom_out0 = irom[irom_addr0];
  assign irom_out1 = irom[irom_addr1];

  always #5 clk = ~clk;

  mcpu_ifetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .irom_addr0     (irom_addr0),
    .irom_addr1     (irom_addr1),
    .irom_out0      (irom_out0),
    .irom_out1      (irom_out1),
    .pop            (pop),
    .q_byte0        (q_byte0),
    .q_byte1        (q_byte1),
    .q_count        (q_count),
    .q_pc           (q_pc)
`ifdef MCPU_IFETCH_PERF_EN
    ,
    .perf_flushes   (perf_flushes),
    .perf_starve    (perf_starve)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte queue of fetched instruction bytes plus two PCs.
  logic [7:0] mq [$];
  int         m_fpc, m_qpc, m_fl, m_st;
  bit         m_run;

  function automatic void model_reset();
    mq.delete();
    m_fpc = 0;
    m_qpc = 0;
    m_run = 1'b0;
    m_fl  = 0;
    m_st  = 0;
  endfunction

  function automatic void model_step(input bit e, input bit rv, input int ra, input int p);
    int ep, ps, sz;
    if (rv) begin
      mq.delete();
      m_fpc = ra & MASK;
      m_qpc = ra & MASK;
      if (m_fl < 65535) m_fl++;
    end else begin
      sz = mq.size();
      if (m_run && sz == 0 && m_st < 65535) m_st++;
      ep = (p > 2) ? 2 : p;
      if (ep > sz) ep = sz;
      ps = 0;
      if (m_run) ps = ((QD - sz) < 2) ? (QD - sz) : 2;
      for (int k = 0; k < ep; k++) void'(mq.pop_front());
      for (int k = 0; k < ps; k++) mq.push_back(irom[(m_fpc + k) & MASK]);
      m_fpc = (m_fpc + ps) & MASK;
      m_qpc = (m_qpc + ep) & MASK;
    end
    m_run = e;
  endfunction

  task automatic check_model();
    check("q_count", q_count, mq.size());
    check("q_pc", q_pc, m_qpc);
    check("irom_addr0", irom_addr0, m_fpc);
    check("irom_addr1", irom_addr1, (m_fpc + 1) & MASK);
    if (mq.size() >= 1) check("q_byte0", q_byte0, mq[0]);
    if (mq.size() >= 2) check("q_byte1", q_byte1, mq[1]);
    check("invariant", irom_addr0, (int'(q_pc) + int'(q_count)) & MASK);
`ifdef MCPU_IFETCH_PERF_EN
    check("perf_flushes", perf_flushes, m_fl);
    check("perf_starve", perf_starve, m_st);
`endif
  endtask

  task automatic step(input bit e, input bit rv, input int ra, input int p);
    logic [31:0] ra_v, p_v;
    ra_v = ra;
    p_v  = p;
    en             = e;
    redirect_valid = rv;
    redirect_addr  = ra_v[AW-1:0];
    pop            = p_v[1:0];
    model_step(e, rv, ra, p);
    @(posedge clk);
    #1;
    check_model();
  endtask

  typedef struct {
    bit e;
    bit rv;
    int ra;
    int p;
    int cnt;
    int qpc;
    int a0;
    int b0;
    int b1;
    int chk;
  } vec_t;

  vec_t tbl [$];

  initial begin
    rst_n          = 1'b0;
    en             = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    pop            = 2'd0;
    for (int i = 0; i < (1 << AW); i++) irom[i] = 8'($urandom);
    for (int i = 0; i < 32; i++) irom[i] = 8'(8'h10 + i);
    irom[MASK] = 8'hA5;
    model_reset();

    //          e rv ra      p  cnt qpc     a0      b0     b1    chk
    tbl.push_back('{1, 0, 0,      0, 0, 0,      0,      0,     0,    0});
    tbl.push_back('{1, 0, 0,      0, 2, 0,      2,      'h10,  'h11, 3});
    tbl.push_back('{1, 0, 0,      0, 4, 0,      4,      'h10,  'h11, 3});
    tbl.push_back('{1, 0, 0,      0, 4, 0,      4,      'h10,  'h11, 3});
    tbl.push_back('{1, 0, 0,      2, 2, 2,      4,      'h12,  'h13, 3});
    tbl.push_back('{1, 0, 0,      2, 2, 4,      6,      'h14,  'h15, 3});
    tbl.push_back('{1, 0, 0,      2, 2, 6,      8,      'h16,  'h17, 3});
    tbl.push_back('{1, 0, 0,      0, 4, 6,      10,     'h16,  'h17, 3});
    tbl.push_back('{0, 0, 0,      3, 2, 8,      10,     'h18,  'h19, 3});
    tbl.push_back('{0, 0, 0,      1, 1, 9,      10,     'h19,  0,    1});
    tbl.push_back('{1, 0, 0,      0, 1, 9,      10,     'h19,  0,    1});
    tbl.push_back('{1, 0, 0,      3, 2, 10,     12,     'h1A,  'h1B, 3});
    tbl.push_back('{1, 0, 0,      1, 3, 11,     14,     'h1B,  'h1C, 3});
    tbl.push_back('{0, 0, 0,      1, 3, 12,     15,     'h1C,  'h1D, 3});
    tbl.push_back('{0, 0, 0,      1, 2, 13,     15,     'h1D,  'h1E, 3});
    tbl.push_back('{0, 0, 0,      1, 1, 14,     15,     'h1E,  0,    1});
    tbl.push_back('{0, 0, 0,      1, 0, 15,     15,     0,     0,    0});
    tbl.push_back('{1, 0, 0,      0, 0, 15,     15,     0,     0,    0});
    tbl.push_back('{1, 0, 0,      0, 2, 15,     17,     'h1F,  'h20, 3});
    tbl.push_back('{1, 1, 'h3FFF, 2, 0, 'h3FFF, 'h3FFF, 0,     0,    0});
    tbl.push_back('{1, 0, 0,      2, 2, 'h3FFF, 1,      'hA5,  'h10, 3});

    #12;
    check("reset_count", q_count, 0);
    check("reset_q_pc", q_pc, 0);
    check("reset_byte0", q_byte0, 0);
    check("reset_byte1", q_byte1, 0);
    check("reset_addr0", irom_addr0, 0);
    check("reset_addr1", irom_addr1, 1);
    #1 rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].e, tbl[i].rv, tbl[i].ra, tbl[i].p);
      check($sformatf("tbl%0d_count", i), q_count, tbl[i].cnt);
      check($sformatf("tbl%0d_q_pc", i), q_pc, tbl[i].qpc);
      check($sformatf("tbl%0d_addr0", i), irom_addr0, tbl[i].a0);
      if (tbl[i].chk[0]) check($sformatf("tbl%0d_byte0", i), q_byte0, tbl[i].b0);
      if (tbl[i].chk[1]) check($sformatf("tbl%0d_byte1", i), q_byte1, tbl[i].b1);
    end
    check("wrap_addr1_after_redirect", (32'(irom_addr0) == 1) ? 32'd1 : 32'd0, 1);

    for (int n = 0; n < 600; n++) begin
      bit e, rv;
      int ra, p;
      e  = ($urandom % 8) != 0;
      rv = ($urandom % 20) == 0;
      ra = ($urandom % 4 == 0) ? (MASK - int'($urandom % 3)) : int'($urandom & MASK);
      p  = int'($urandom % 4);
      step(e, rv, ra, p);
    end

    // Reset in the middle of a stream with three bytes queued.
    step(1, 1, 'h100, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    check("pre_reset_count", q_count, 3);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst_count", q_count, 0);
    check("midrst_q_pc", q_pc, 0);
    check("midrst_byte0", q_byte0, 0);
    check("midrst_byte1", q_byte1, 0);
    check("midrst_addr0", irom_addr0, 0);
`ifdef MCPU_IFETCH_PERF_EN
    check("midrst_perf_flushes", perf_flushes, 0);
    check("midrst_perf_starve", perf_starve, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 100; n++) begin
      step(($urandom % 6) != 0, ($urandom % 25) == 0, int'($urandom & MASK), int'($urandom % 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
